// File: rtl/mealy_stream_arbiter_pkg.sv
// Shared encodings for the Mealy stream arbiter: engine states and controller states.
package mealy_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } eng_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/mealy_stream_arbiter_if.sv
// Request/response bundle between two requesters and the Mealy stream arbiter.
interface mealy_stream_arbiter_if
  import mealy_stream_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
);
  // Handshake: a word moves when reqN_valid && reqN_ready are both high at a rising edge;
  // ready is combinational and may be high only in IDLE; rsp_valid is a one-cycle pulse, no backpressure.
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  eng_state_t       rsp_state;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_state, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_state, busy
  );
endinterface

// File: rtl/mealy_stream_arbiter_mealy_core.sv
// Four-state Mealy engine: y is combinational from (state, x); clr restarts it at S0.
module mealy_core
  import mealy_stream_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       x,
  output logic       y,
  output eng_state_t state
);

  eng_state_t state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= S0;
    else if (clr) state <= S0;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    y       = 1'b0;
    case (state)
      S0: if (x) begin state_d = S0; y = 1'b1; end
          else   begin state_d = S1; y = 1'b0; end
      S1: if (x) begin state_d = S3; y = 1'b0; end
          else   begin state_d = S2; y = 1'b1; end
      S2: if (x) begin state_d = S1; y = 1'b0; end
          else   begin state_d = S0; y = 1'b1; end
      S3: if (x) begin state_d = S2; y = 1'b1; end
          else   begin state_d = S3; y = 1'b0; end
      default: begin state_d = S0; y = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mealy_stream_arbiter.sv
// Round-robin arbiter for two requesters feeding one word at a time, MSB first,
// through a Mealy engine and returning the collected y bits.
module mealy_stream_arbiter
  import mealy_stream_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mealy_stream_arbiter_if.slave bus,
  output ctrl_state_t           fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(WIDTH);

  ctrl_state_t      state_q, state_d;
  logic             grant, last_grant_q;
  logic             accept0, accept1, accept;
  logic [WIDTH-1:0] word_q, res_q, hold_data_q;
  logic [CW-1:0]    cnt_q;
  logic             id_q, hold_id_q;
  eng_state_t       eng_state, hold_state_q;
  logic             x, y, last_bit;

  // Tie goes to whoever did not win last time.
  always_comb begin
    grant = ~last_grant_q;
    if (bus.req0_valid && !bus.req1_valid)      grant = 1'b0;
    else if (bus.req1_valid && !bus.req0_valid) grant = 1'b1;
  end

  assign accept0  = (state_q == IDLE) && bus.req0_valid && !grant;
  assign accept1  = (state_q == IDLE) && bus.req1_valid &&  grant;
  assign accept   = accept0 || accept1;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);
  assign x        = (state_q == SHIFT) ? word_q[WIDTH-1] : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      word_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      hold_data_q  <= '0;
      hold_state_q <= S0;
      hold_id_q    <= 1'b0;
    end else begin
      if (accept) begin
        word_q       <= accept1 ? bus.req1_data : bus.req0_data;
        id_q         <= accept1;
        last_grant_q <= accept1;
        cnt_q        <= '0;
      end
      if (state_q == SHIFT) begin
        word_q <= {word_q[WIDTH-2:0], 1'b0};
        res_q  <= {res_q[WIDTH-2:0], y};
        if (cnt_q != MAX_CNT) cnt_q <= cnt_q + 1'b1;
      end
      // Freeze the result so it survives the next word's SHIFT phase.
      if (state_q == DONE) begin
        hold_data_q  <= res_q;
        hold_state_q <= eng_state;
        hold_id_q    <= id_q;
      end
    end
  end

  mealy_core u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .x     (x),
    .y     (y),
    .state (eng_state)
  );

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_id     = (state_q == DONE) ? id_q      : hold_id_q;
  assign bus.rsp_data   = (state_q == DONE) ? res_q     : hold_data_q;
  assign bus.rsp_state  = (state_q == DONE) ? eng_state : hold_state_q;
  assign bus.busy       = (state_q != IDLE);
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_mealy_stream_arbiter.sv
// Directed bench: drivers push expected responses, a negedge monitor pops and compares.
module tb_mealy_stream_arbiter;
  import mealy_stream_arbiter_pkg::*;

  localparam int WIDTH = 8;
  localparam int EW    = 1 + 2 + WIDTH;

  logic        clk;
  logic        rst;
  ctrl_state_t fsm_state;
  int          checks;
  int          errors;
  int          cyc;
  logic [WIDTH-1:0] hold_exp;
  logic [EW-1:0]    exp_q[$];
  int               exp_cyc_q[$];

  mealy_stream_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mealy_stream_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] got, exp;
    int            ecyc;
    if (!rst) begin
      hold_exp = '0;
    end else begin
      checks++;
      if (bus.req0_ready && bus.req1_ready) begin
        errors++;
        $display("FAIL both_ready cyc=%0d got=11 want=not both", cyc);
      end
      if (bus.rsp_valid) begin
        got = {bus.rsp_id, bus.rsp_state, bus.rsp_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp cyc=%0d got=%h want=none", cyc, got);
        end else begin
          exp  = exp_q.pop_front();
          ecyc = exp_cyc_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL rsp_fields cyc=%0d got id=%0d st=%0d data=%h want id=%0d st=%0d data=%h",
                     cyc, got[EW-1], got[EW-2 -: 2], got[WIDTH-1:0],
                     exp[EW-1], exp[EW-2 -: 2], exp[WIDTH-1:0]);
          end
          checks++;
          if (cyc != ecyc) begin
            errors++;
            $display("FAIL rsp_cycle got=%0d want=%0d", cyc, ecyc);
          end
          hold_exp = exp[WIDTH-1:0];
        end
      end else begin
        checks++;
        if (bus.rsp_data !== hold_exp) begin
          errors++;
          $display("FAIL rsp_hold cyc=%0d got=%h want=%h", cyc, bus.rsp_data, hold_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic apply_reset();
    rst            = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_state, bus.rsp_data, bus.busy,
         bus.req0_ready, bus.req1_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b id=%b st=%0d d=%h busy=%b r0=%b r1=%b want all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_state, bus.rsp_data, bus.busy,
               bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic set_req(input bit id, input logic v, input logic [WIDTH-1:0] d);
    if (id) begin bus.req1_valid = v; bus.req1_data = d; end
    else    begin bus.req0_valid = v; bus.req0_data = d; end
  endtask

  task automatic push_exp(input bit id, input eng_state_t es, input logic [WIDTH-1:0] ed);
    exp_q.push_back({id, es, ed});
    exp_cyc_q.push_back(cyc + WIDTH + 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout got busy=1 want busy=0");
    end
  endtask

  task automatic send(input bit id, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] ed, input eng_state_t es);
    bit got;
    @(posedge clk);
    #1 set_req(id, 1'b1, d);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout id=%0d got ready=0 want ready=1", id);
    end else begin
      push_exp(id, es, ed);
    end
    // Valid still high in the first SHIFT cycle: ready must stay low.
    @(negedge clk);
    checks++;
    if ((id ? bus.req1_ready : bus.req0_ready) !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL ready_during_shift id=%0d got ready=%b busy=%b want ready=0 busy=1",
               id, id ? bus.req1_ready : bus.req0_ready, bus.busy);
    end
    @(posedge clk);
    #1 set_req(id, 1'b0, d);
    wait_idle();
  endtask

  // Stimulus
  initial begin
    int acc, last_acc;
    bit rid, ok;
    checks = 0;
    errors = 0;
    hold_exp = '0;

    apply_reset();
    send(1'b0, 8'hFF, 8'hFF, S0);
    send(1'b1, 8'h00, 8'h6D, S2);
    send(1'b0, 8'hA5, 8'h87, S0);

    // Both requesters valid continuously: grants alternate, one accept per WIDTH+2 cycles.
    apply_reset();
    set_req(1'b0, 1'b1, 8'hFF);
    set_req(1'b1, 1'b1, 8'h00);
    acc = 0;
    last_acc = 0;
    for (int n = 0; n < 80 && acc < 4; n++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        rid = bus.req1_ready;
        checks++;
        if (rid !== acc[0]) begin
          errors++;
          $display("FAIL rr_grant acc=%0d got=%0d want=%0d", acc, rid, acc[0]);
        end
        if (acc > 0) begin
          checks++;
          if (cyc - last_acc != WIDTH + 2) begin
            errors++;
            $display("FAIL rr_spacing got=%0d want=%0d", cyc - last_acc, WIDTH + 2);
          end
        end
        if (rid) push_exp(1'b1, S2, 8'h6D);
        else     push_exp(1'b0, S0, 8'hFF);
        last_acc = cyc;
        acc++;
      end
    end
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL rr_accepts got=%0d want=4", acc);
    end
    @(posedge clk);
    #1 begin set_req(1'b0, 1'b0, 8'hFF); set_req(1'b1, 1'b0, 8'h00); end
    wait_idle();

    // Reset in the 4th SHIFT cycle aborts the word; first cycle after release accepts.
    apply_reset();
    @(posedge clk);
    #1 set_req(1'b0, 1'b1, 8'hA5);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.req0_ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_accept got ready=0 want ready=1");
    end
    @(posedge clk);
    #1 set_req(1'b0, 1'b0, 8'hA5);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL async_reset got busy=%b rsp_valid=%b state=%0d want 0 0 0",
               bus.busy, bus.rsp_valid, fsm_state);
    end
    repeat (2) @(posedge clk);
    #1 begin rst = 1'b1; set_req(1'b1, 1'b1, 8'h00); end
    @(negedge clk);
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_accept got ready=%b want ready=1", bus.req1_ready);
    end else begin
      push_exp(1'b1, S2, 8'h6D);
    end
    @(posedge clk);
    #1 set_req(1'b1, 1'b0, 8'h00);
    wait_idle();
    repeat (5) @(posedge clk);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_rsp got pending=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
